// File: rtl/tandy_keyboard_sequencer.sv
// rtl/tandy_keyboard_sequencer.sv - PS/2 set-1 scancode sequencer for the Tandy converter (option macro: TANDY_KBD_OVERRUN_CODE_EN)
module tandy_keyboard_sequencer #(
    parameter int FIFO_DEPTH      = 16,
    parameter int IRQ_HIGH_CYCLES = 2,
    parameter int IRQ_LOW_CYCLES  = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] ps2_data,
    input  logic       ps2_valid,
    output logic [7:0] conv_scancode,
    output logic       conv_irq,
    input  logic [7:0] conv_data,
    output logic [7:0] kbd_data,
    output logic       kbd_irq,
    input  logic       kbd_ack,
    input  logic       kbd_flush,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int MAX_CYC = (IRQ_HIGH_CYCLES > IRQ_LOW_CYCLES) ? IRQ_HIGH_CYCLES : IRQ_LOW_CYCLES;
    localparam int CW = $clog2(MAX_CYC);
    localparam logic [CW-1:0] HI_LAST = CW'(IRQ_HIGH_CYCLES - 1);
    localparam logic [CW-1:0] LO_LAST = CW'(IRQ_LOW_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE_HI,
        S_DRIVE_LO,
        S_DELIVER,
        S_WAIT_ACK
    } state_t;

    // Raw scancode FIFO; pointers carry one extra wrap bit to tell full from empty
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty, fifo_full, fifo_pop, fifo_push, push_drop;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    scancode_q, scancode_d;
    logic          conv_irq_q, conv_irq_d;
    logic [7:0]    capture_q, capture_d;
    logic [7:0]    kbd_data_q, kbd_data_d;
    logic          kbd_irq_q, kbd_irq_d;
    logic          overflow_q, overflow_d;
`ifdef TANDY_KBD_OVERRUN_CODE_EN
    logic          ovr_pend_q, ovr_pend_d;
`endif

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // The FSM only consumes in IDLE; a flush cancels both the pop and any push that cycle
    assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty && !kbd_flush;
    assign fifo_push = ps2_valid && !kbd_flush && (!fifo_full || fifo_pop);
    assign push_drop = ps2_valid && !kbd_flush && fifo_full && !fifo_pop;

    // FIFO storage write; contents need no reset because the pointers gate visibility
    always_ff @(posedge clock) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= ps2_data;
        end
    end

    // FIFO pointers, cleared by reset and by flush
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (kbd_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Sequencer next-state: replay each byte as an IRQ pulse pair, then hand it to the CPU
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scancode_d = scancode_q;
        capture_d  = capture_q;
        kbd_data_d = kbd_data_q;
        kbd_irq_d  = kbd_irq_q;
        overflow_d = overflow_q | push_drop;
`ifdef TANDY_KBD_OVERRUN_CODE_EN
        ovr_pend_d = ovr_pend_q | push_drop;
`endif
        case (state_q)
            S_IDLE: begin
                if (fifo_pop) begin
                    scancode_d = fifo_mem[rd_ptr_q[AW-1:0]];
                    cnt_d      = '0;
                    state_d    = S_DRIVE_HI;
                end
`ifdef TANDY_KBD_OVERRUN_CODE_EN
                else if (fifo_empty && ovr_pend_q) begin
                    // Overrun marker bypasses the converter entirely
                    kbd_data_d = 8'hFF;
                    kbd_irq_d  = 1'b1;
                    ovr_pend_d = 1'b0;
                    state_d    = S_WAIT_ACK;
                end
`endif
            end
            S_DRIVE_HI: begin
                if (cnt_q == HI_LAST) begin
                    capture_d = conv_data;
                    cnt_d     = '0;
                    state_d   = S_DRIVE_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRIVE_LO: begin
                if (cnt_q == LO_LAST) begin
                    cnt_d = '0;
                    // E0 only arms the converter; it is never shown to the CPU
                    state_d = (scancode_q == 8'hE0) ? S_IDLE : S_DELIVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DELIVER: begin
                kbd_data_d = capture_q;
                kbd_irq_d  = 1'b1;
                state_d    = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (kbd_ack) begin
                    kbd_irq_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (kbd_flush) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            kbd_irq_d  = 1'b0;
            overflow_d = 1'b0;
`ifdef TANDY_KBD_OVERRUN_CODE_EN
            ovr_pend_d = 1'b0;
`endif
        end
        // Registered IRQ decode keeps the converter's clock-like input glitch-free
        conv_irq_d = (state_d == S_DRIVE_HI);
    end

    // Sequencer state and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            scancode_q <= 8'h00;
            conv_irq_q <= 1'b0;
            capture_q  <= 8'h00;
            kbd_data_q <= 8'h00;
            kbd_irq_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scancode_q <= scancode_d;
            conv_irq_q <= conv_irq_d;
            capture_q  <= capture_d;
            kbd_data_q <= kbd_data_d;
            kbd_irq_q  <= kbd_irq_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef TANDY_KBD_OVERRUN_CODE_EN
    // Pending-overrun flag: one FFh per overflow episode
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovr_pend_q <= 1'b0;
        end else begin
            ovr_pend_q <= ovr_pend_d;
        end
    end
`endif

    assign conv_scancode = scancode_q;
    assign conv_irq      = conv_irq_q;
    assign kbd_data      = kbd_data_q;
    assign kbd_irq       = kbd_irq_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_tandy_keyboard_sequencer.sv
// tb/tb_tandy_keyboard_sequencer.sv - self-checking bench for tandy_keyboard_sequencer
`timescale 1ns/1ps
module tb_tandy_keyboard_sequencer;

    localparam int DEPTH = 16;
    localparam int HI    = 2;

    logic       clock     = 1'b0;
    logic       reset_n   = 1'b0;
    logic [7:0] ps2_data  = 8'h00;
    logic       ps2_valid = 1'b0;
    logic [7:0] conv_scancode;
    logic       conv_irq;
    logic [7:0] conv_data = 8'h00;
    logic [7:0] kbd_data;
    logic       kbd_irq;
    logic       kbd_ack   = 1'b0;
    logic       kbd_flush = 1'b0;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    tandy_keyboard_sequencer #(
        .FIFO_DEPTH(DEPTH), .IRQ_HIGH_CYCLES(HI), .IRQ_LOW_CYCLES(2)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .ps2_data(ps2_data), .ps2_valid(ps2_valid),
        .conv_scancode(conv_scancode), .conv_irq(conv_irq), .conv_data(conv_data),
        .kbd_data(kbd_data), .kbd_irq(kbd_irq), .kbd_ack(kbd_ack),
        .kbd_flush(kbd_flush), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Converter translation rules for the codes this bench uses
    function automatic logic [7:0] tandy_map(input bit ext, input logic [7:0] code);
        if (ext && code[6:0] == 7'h48)  return {code[7], 7'h29};
        if (!ext && code[6:0] == 7'h4A) return {code[7], 7'h53};
        return code;
    endfunction

    // Converter model: translates on the IRQ rising edge, E0 arms the extended flag
    logic conv_e0 = 1'b0;
    always @(posedge conv_irq) begin
        conv_data = tandy_map(conv_e0, conv_scancode);
        conv_e0   = (conv_scancode == 8'hE0);
    end

    // Bus monitor
    logic [7:0] delivered[$];
    logic [7:0] pulses[$];
    int  pulse_while_irq = 0, e0_leak = 0, unstable = 0, hi_cnt = 0, last_width = 0;
    bit  in_e0 = 0;
    logic prev_ci = 1'b0, prev_ki = 1'b0;
    logic [7:0] pulse_code = 8'h00;
    always @(negedge clock) begin
        if (conv_irq && !prev_ci) begin
            pulses.push_back(conv_scancode);
            pulse_code = conv_scancode;
            if (kbd_irq) pulse_while_irq++;
            in_e0  = (conv_scancode == 8'hE0);
            hi_cnt = 1;
        end else if (conv_irq) begin
            hi_cnt++;
            if (conv_scancode != pulse_code) unstable++;
        end else if (prev_ci) begin
            last_width = hi_cnt;
        end
        if (kbd_irq && !prev_ki) begin
            delivered.push_back(kbd_data);
            if (in_e0) e0_leak++;
        end
        prev_ci = conv_irq;
        prev_ki = kbd_irq;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        ps2_data  = b;
        ps2_valid = 1'b1;
        tick();
        ps2_valid = 1'b0;
    endtask

    task automatic ack();
        kbd_ack = 1'b1;
        tick();
        kbd_ack = 1'b0;
    endtask

    task automatic wait_irq(input string name);
        int n = 0;
        while (!kbd_irq && n < 300) begin
            tick();
            n++;
        end
        check({name, " irq timeout"}, kbd_irq, 1);
    endtask

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [0:5];

    initial begin
        int base;
        logic [7:0] bytes[$];
        logic [7:0] expq[$];
        bit e0;
        logic [7:0] pool [0:5];

        vecs = '{'{1'b0, 8'h1E, 8'h1E}, '{1'b0, 8'h4A, 8'h53}, '{1'b0, 8'hCA, 8'hD3},
                 '{1'b1, 8'h48, 8'h29}, '{1'b1, 8'hC8, 8'hA9}, '{1'b0, 8'h30, 8'h30}};
        pool = '{8'h4A, 8'hCA, 8'h48, 8'hC8, 8'h1E, 8'h9E};

        // Reset values
        tick(3);
        check("rst conv_scancode", conv_scancode, 8'h00);
        check("rst conv_irq", conv_irq, 0);
        check("rst kbd_data", kbd_data, 8'h00);
        check("rst kbd_irq", kbd_irq, 0);
        check("rst overflow", overflow, 0);
        reset_n = 1'b1;
        tick(2);

        // Table-driven single keys
        for (int i = 0; i < 6; i++) begin
            base = pulses.size();
            if (vecs[i].ext) push(8'hE0);
            push(vecs[i].code);
            wait_irq("vec");
            check($sformatf("vec%0d kbd_data", i), kbd_data, vecs[i].exp);
            check($sformatf("vec%0d pulses", i), pulses.size() - base, vecs[i].ext ? 2 : 1);
            check($sformatf("vec%0d pulse code", i), pulses[pulses.size()-1], vecs[i].code);
            if (i == 0) check("pulse width", last_width, HI);
            tick(5);
            check($sformatf("vec%0d hold irq", i), kbd_irq, 1);
            ack();
            check($sformatf("vec%0d irq clear", i), kbd_irq, 0);
        end

        // 4Ah then CAh back to back: second pulse waits for the first ack
        base = pulses.size();
        push(8'h4A);
        push(8'hCA);
        wait_irq("pair1");
        check("pair first", kbd_data, 8'h53);
        tick(10);
        check("pair no early pulse", pulses.size() - base, 1);
        ack();
        wait_irq("pair2");
        check("pair second", kbd_data, 8'hD3);
        ack();

        // Extended key with the follow-on byte delayed
        base = pulses.size();
        push(8'hE0);
        tick(50);
        check("e0 wait no irq", kbd_irq, 0);
        push(8'h48);
        wait_irq("e0 delayed");
        check("e0 delayed data", kbd_data, 8'h29);
        check("e0 delayed pulses", pulses.size() - base, 2);
        ack();

        // Backpressure: one byte held unacked, then DEPTH+2 pushes
        push(8'h55);
        wait_irq("bp hold");
        for (int i = 1; i <= DEPTH + 2; i++) push(8'(i));
        check("bp overflow", overflow, 1);
        check("bp head", kbd_data, 8'h55);
        ack();
        for (int i = 1; i <= DEPTH; i++) begin
            wait_irq("bp");
            check($sformatf("bp byte %0d", i), kbd_data, 8'(i));
            ack();
        end
`ifdef TANDY_KBD_OVERRUN_CODE_EN
        wait_irq("bp overrun");
        check("bp overrun code", kbd_data, 8'hFF);
        ack();
`endif
        tick(30);
        check("bp lost bytes", kbd_irq, 0);
        check("bp overflow sticky", overflow, 1);

        // Flush during DRIVE_HI, with a coincident push that must be discarded
        push(8'h61);
        push(8'h62);
        push(8'h63);
        for (int n = 0; n < 20 && !conv_irq; n++) tick();
        check("flush saw drive_hi", conv_irq, 1);
        kbd_flush = 1'b1;
        ps2_data  = 8'h77;
        ps2_valid = 1'b1;
        tick();
        kbd_flush = 1'b0;
        ps2_valid = 1'b0;
        check("flush conv_irq", conv_irq, 0);
        check("flush kbd_irq", kbd_irq, 0);
        check("flush overflow", overflow, 0);
        base = pulses.size();
        tick(60);
        check("flush no pulses", pulses.size() - base, 0);
        check("flush no delivery", kbd_irq, 0);

        // Randomized key streams against the scancode-stream model
        for (int r = 0; r < 8; r++) begin
            bytes.delete();
            expq.delete();
            for (int k = 0; k < $urandom_range(1, 5); k++) begin
                logic [7:0] c;
                if ($urandom_range(0, 1) == 1) c = pool[$urandom_range(0, 5)];
                else c = 8'($urandom_range(1, 255));
                if (c == 8'hE0) c = 8'h2C;
                if ($urandom_range(0, 2) == 0) bytes.push_back(8'hE0);
                bytes.push_back(c);
            end
            e0 = 0;
            foreach (bytes[j]) begin
                if (bytes[j] == 8'hE0) e0 = 1;
                else begin
                    expq.push_back(tandy_map(e0, bytes[j]));
                    e0 = 0;
                end
            end
            base = delivered.size();
            fork
                begin
                    foreach (bytes[j]) begin
                        push(bytes[j]);
                        tick($urandom_range(0, 4));
                    end
                end
                begin
                    for (int j = 0; j < expq.size(); j++) begin
                        wait_irq("rand");
                        tick($urandom_range(0, 3));
                        ack();
                    end
                end
            join
            tick(20);
            check($sformatf("rand%0d count", r), delivered.size() - base, expq.size());
            for (int j = 0; j < expq.size() && base + j < delivered.size(); j++)
                check($sformatf("rand%0d byte%0d", r, j), delivered[base + j], expq[j]);
        end
        check("rand overflow", overflow, 0);

        // Asynchronous reset while waiting for ack
        push(8'h5A);
        wait_irq("rst hold");
        check("rst pre data", kbd_data, 8'h5A);
        reset_n = 1'b0;
        #1;
        check("arst conv_scancode", conv_scancode, 8'h00);
        check("arst conv_irq", conv_irq, 0);
        check("arst kbd_data", kbd_data, 8'h00);
        check("arst kbd_irq", kbd_irq, 0);
        check("arst overflow", overflow, 0);
        tick(2);
        reset_n = 1'b1;
        tick();
        push(8'h30);
        wait_irq("post rst");
        check("post rst data", kbd_data, 8'h30);
        ack();

        check("pulse before ack", pulse_while_irq, 0);
        check("e0 delivered", e0_leak, 0);
        check("scancode stable", unstable, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
